// File: rtl/pr_query_arbiter.sv
// pr_query_arbiter
//   Round-robin arbiter for a shared query/reply network between NANT ant
//   nodes. A granted ant's page index is broadcast as a query. After LAT
//   cycles the owner ant's reply (selected by the top two page bits) is
//   captured. The {value, page} response then goes back to the requester.
//   Only one transaction is in flight at a time.
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous, active-high
//   req_valid    [NANT]          per-ant request pending
//   req_page     [NANT*PAGEW]    requested page, ant i at [i*PAGEW +: PAGEW]
//   req_ack      [NANT]          one-hot grant pulse (IDLE cycle of the grant)
//   query        [PAGEW]         page broadcast to all ants (holds when idle)
//   query_valid                  query live (QUERY/CAPTURE)
//   reply_in     [NANT*WIDTH]    reply value per ant, ant i at [i*WIDTH +: WIDTH]
//   response     [WIDTH+PAGEW]   {value, page} to the requester (holds)
//   resp_valid   [NANT]          one-hot response pulse
//   sweep_done                   pulse with the SWEEP-th response
//   busy                         state is not IDLE
module pr_query_arbiter #(
    parameter int NANT  = 4,
    parameter int WIDTH = 16,
    parameter int PAGEW = 6,
    parameter int SWEEP = 64,
    parameter int LAT   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NANT-1:0]          req_valid,
    input  logic [NANT*PAGEW-1:0]    req_page,
    output logic [NANT-1:0]          req_ack,
    output logic [PAGEW-1:0]         query,
    output logic                     query_valid,
    input  logic [NANT*WIDTH-1:0]    reply_in,
    output logic [WIDTH+PAGEW-1:0]   response,
    output logic [NANT-1:0]          resp_valid,
    output logic                     sweep_done,
    output logic                     busy
);

    localparam int IDW  = (NANT > 1) ? $clog2(NANT) : 1;
    localparam int CNTW = $clog2(SWEEP + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_QUERY   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    logic [1:0]       state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_found;
    logic [PAGEW-1:0] page_q;
    logic [WIDTH-1:0] value_q;
    logic [2:0]       lat_cnt;
    logic [CNTW-1:0]  tx_cnt;
    logic [1:0]       owner;
    int unsigned      idx;

    assign owner = page_q[PAGEW-1 -: 2];
    assign busy  = (state != S_IDLE);

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NANT; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NANT) idx = idx - NANT;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(idx);
            end
        end
    end

    // The grant pulse is visible in the IDLE cycle that makes the decision.
    // It is gated by reset so nothing is acknowledged while held in reset.
    always_comb begin
        req_ack = '0;
        if (!reset && state == S_IDLE && gnt_found)
            req_ack[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            page_q      <= '0;
            value_q     <= '0;
            lat_cnt     <= '0;
            tx_cnt      <= '0;
            query       <= '0;
            query_valid <= 1'b0;
            response    <= '0;
            resp_valid  <= '0;
            sweep_done  <= 1'b0;
        end else begin
            resp_valid <= '0;
            sweep_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (gnt_found) begin
                        grant_id    <= gnt_idx;
                        page_q      <= req_page[32'(gnt_idx)*PAGEW +: PAGEW];
                        query       <= req_page[32'(gnt_idx)*PAGEW +: PAGEW];
                        query_valid <= 1'b1;
                        lat_cnt     <= 3'd1;
                        rr_ptr      <= (gnt_idx == IDW'(NANT - 1)) ? '0 : gnt_idx + 1'b1;
                        state       <= S_QUERY;
                    end
                end
                S_QUERY: begin
                    if (lat_cnt == 3'(LAT)) state <= S_CAPTURE;
                    else                    lat_cnt <= lat_cnt + 3'd1;
                end
                S_CAPTURE: begin
                    value_q     <= reply_in[32'(owner)*WIDTH +: WIDTH];
                    query_valid <= 1'b0;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    // Registered outputs: the response and sweep pulse appear
                    // together one cycle after RESP, i.e. LAT+3 after grant.
                    response             <= {value_q, page_q};
                    resp_valid[grant_id] <= 1'b1;
                    if (tx_cnt == CNTW'(SWEEP - 1)) begin
                        tx_cnt     <= '0;
                        sweep_done <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pr_query_arbiter.sv
// tb_pr_query_arbiter
//   Directed bench for pr_query_arbiter. It uses a default instance (LAT=1)
//   and a second instance with LAT=3. Both share clk, reset and reply_in.
module tb_pr_query_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid, req_valid3;
    logic [23:0] req_page, req_page3;
    logic [63:0] reply_in;

    logic [3:0]  req_ack, req_ack3;
    logic [5:0]  query, query3;
    logic        query_valid, query_valid3;
    logic [21:0] response, response3;
    logic [3:0]  resp_valid, resp_valid3;
    logic        sweep_done, sweep_done3;
    logic        busy, busy3;

    int checks = 0;
    int errors = 0;
    int sd_count = 0;
    logic        sd_at_resp;
    logic [21:0] last_resp;
    int ant_hits [4];

    always #5 clk = ~clk;

    pr_query_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_page(req_page),
        .req_ack(req_ack), .query(query), .query_valid(query_valid),
        .reply_in(reply_in), .response(response), .resp_valid(resp_valid),
        .sweep_done(sweep_done), .busy(busy)
    );

    pr_query_arbiter #(.LAT(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid3), .req_page(req_page3),
        .req_ack(req_ack3), .query(query3), .query_valid(query_valid3),
        .reply_in(reply_in), .response(response3), .resp_valid(resp_valid3),
        .sweep_done(sweep_done3), .busy(busy3)
    );

    task automatic step;
        @(posedge clk);
        #1;
        if (sweep_done === 1'b1) sd_count++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a grant, check it, then wait (bounded) for the
    // response and check its latency and target.
    task automatic serve(input string tag, input logic [3:0] exp_onehot,
                         input logic [3:0] clr, input int exp_lat);
        int n;
        int lat;
        #1;
        n = 0;
        while (req_ack === 4'b0 && n < 40) begin step(); n++; end
        chk({tag, "_ack"}, 32'(req_ack), 32'(exp_onehot));
        step();
        req_valid = req_valid & ~clr;
        lat = 1;
        while (resp_valid === 4'b0 && lat < 40) begin step(); lat++; end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rv"}, 32'(resp_valid), 32'(exp_onehot));
        last_resp  = response;
        sd_at_resp = sweep_done;
        for (int i = 0; i < 4; i++) if (resp_valid[i] === 1'b1) ant_hits[i]++;
    endtask

    initial begin
        int qcnt;
        int rcyc;
        logic [3:0]  rv;
        logic [21:0] rsp;
        logic [3:0]  e;

        reset      = 1'b1;
        req_valid  = 4'b1111;
        req_valid3 = 4'b1111;
        req_page   = '0;
        req_page3  = '0;
        reply_in   = {16'hBEEF, 16'h5555, 16'h1234, 16'hA000};
        for (int i = 0; i < 4; i++) ant_hits[i] = 0;
        step(); step();

        // Held in reset with all requests high
        chk("rst_ack",   32'(req_ack), 32'h0);
        chk("rst_ack3",  32'(req_ack3), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_query", 32'(query), 32'h0);
        chk("rst_qv",    32'(query_valid), 32'h0);
        chk("rst_resp",  32'(response), 32'h0);
        chk("rst_rv",    32'(resp_valid), 32'h0);
        chk("rst_sweep", 32'(sweep_done), 32'h0);
        req_valid  = 4'b0;
        req_valid3 = 4'b0;
        reset      = 1'b0;
        step();

        // LAT=3: ant0 page 0x3F is owned by ant3
        req_page3[5:0] = 6'h3F;
        req_valid3     = 4'b0001;
        #1;
        chk("l3_ack", 32'(req_ack3), 32'h1);
        qcnt = 0; rcyc = 0; rv = '0; rsp = '0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 1) req_valid3 = 4'b0;
            if (query_valid3 === 1'b1) qcnt++;
            if (resp_valid3 !== 4'b0 && rcyc == 0) begin
                rcyc = c; rv = resp_valid3; rsp = response3;
            end
        end
        chk("l3_qv_cycles", 32'(qcnt), 32'd4);
        chk("l3_resp_cyc",  32'(rcyc), 32'd6);
        chk("l3_rv",        32'(rv), 32'h1);
        chk("l3_response",  32'(rsp), 32'({16'hBEEF, 6'h3F}));

        // Single request: ant2 page 0x13, owner ant1
        req_page[17:12] = 6'h13;
        req_valid       = 4'b0100;
        #1;
        chk("t1_ack",  32'(req_ack), 32'h4);
        chk("t1_busy0", 32'(busy), 32'h0);
        step();
        req_valid = 4'b0;
        chk("t1_query", 32'(query), 32'h13);
        chk("t1_qv_q",  32'(query_valid), 32'h1);
        chk("t1_busy1", 32'(busy), 32'h1);
        chk("t1_ack_off", 32'(req_ack), 32'h0);
        step();
        chk("t1_qv_cap", 32'(query_valid), 32'h1);
        step();
        chk("t1_qv_resp", 32'(query_valid), 32'h0);
        chk("t1_rv_early", 32'(resp_valid), 32'h0);
        chk("t1_query_hold", 32'(query), 32'h13);
        step();
        chk("t1_rv",       32'(resp_valid), 32'h4);
        chk("t1_response", 32'(response), 32'({16'h1234, 6'h13}));
        chk("t1_sweep",    32'(sweep_done), 32'h0);
        step();
        chk("t1_rv_pulse", 32'(resp_valid), 32'h0);
        chk("t1_resp_hold", 32'(response), 32'({16'h1234, 6'h13}));

        // rr_ptr is 3; grant ant1 alone so it becomes 2
        req_page[11:6] = 6'h05;
        req_valid      = 4'b0010;
        serve("a1", 4'b0010, 4'b0010, 4);
        chk("a1_response", 32'(last_resp), 32'({16'hA000, 6'h05}));

        // Ant1 and ant3 with rr_ptr=2: ant3 first, then ant1
        req_page[23:18] = 6'h2A;
        req_valid       = 4'b1010;
        serve("rr3", 4'b1000, 4'b1000, 4);
        chk("rr3_response", 32'(last_resp), 32'({16'h5555, 6'h2A}));
        serve("rr1", 4'b0010, 4'b0010, 4);

        // rr_ptr=2 again: grant ant2, then abort with reset during QUERY
        req_valid = 4'b0110;
        #1;
        chk("ab_ack", 32'(req_ack), 32'h4);
        step();
        chk("ab_qv", 32'(query_valid), 32'h1);
        reset = 1'b1;
        #1;
        chk("ab_busy",  32'(busy), 32'h0);
        chk("ab_qv0",   32'(query_valid), 32'h0);
        chk("ab_query", 32'(query), 32'h0);
        chk("ab_resp",  32'(response), 32'h0);
        chk("ab_rv",    32'(resp_valid), 32'h0);
        chk("ab_ack0",  32'(req_ack), 32'h0);
        step();
        reset = 1'b0;
        serve("ab_next", 4'b0010, 4'b0110, 4);

        // All four continuously from reset: 0,1,2,3,0
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) ant_hits[i] = 0;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e = 4'b0001 << (k % 4);
            serve("all4", e, 4'b0, 4);
        end
        req_valid = 4'b0;
        chk("all4_hits0", 32'(ant_hits[0]), 32'd2);
        chk("all4_hits1", 32'(ant_hits[1]), 32'd1);
        chk("all4_hits2", 32'(ant_hits[2]), 32'd1);
        chk("all4_hits3", 32'(ant_hits[3]), 32'd1);

        // Sweep: two full sweeps from reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        sd_count  = 0;
        req_valid = 4'b1111;
        for (int t = 1; t <= 128; t++) begin
            e = 4'b0001 << ((t - 1) % 4);
            serve("sweep", e, 4'b0, 4);
            chk("sweep_at_resp", 32'(sd_at_resp), ((t % 64) == 0) ? 32'd1 : 32'd0);
            if (t == 64) chk("sweep_count64", 32'(sd_count), 32'd1);
        end
        req_valid = 4'b0;
        step(); step();
        chk("sweep_count128", 32'(sd_count), 32'd2);
        chk("idle_busy", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
